// File: rtl/fifo_reader_if.sv
// fifo_reader_if: producer/consumer signal bundle for fifo_reader.
// The master side is the producer/consumer environment; the slave side is the FIFO.
interface fifo_reader_if #(
    parameter int WIDTH = 8
);
    logic             trig_write;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [2:0]       level;
    logic             empty;
    logic             full;
    logic             ovf;

    modport master (
        output trig_write, din, dout_ready,
        input  dout, dout_valid, level, empty, full, ovf
    );

    modport slave (
        input  trig_write, din, dout_ready,
        output dout, dout_valid, level, empty, full, ovf
    );
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader: 4-entry edge-triggered shift FIFO with a registered output stage.
// Optional sticky overflow flag enabled by defining FIFO_READER_OVF_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | nothing presented; wait for a stored entry
// S_LOAD  | one cycle: move oldest entry into dout, pop it, raise dout_valid
// S_VALID | dout presented and held until the consumer accepts it
module fifo_reader #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    fifo_reader_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;

    logic [1:0]       r_state;
    logic             r_trig_d;
    logic             r_trig_hold;
    logic [WIDTH-1:0] r_mem [0:3];
    logic [2:0]       r_level;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;

    logic             w_edge;
    logic             w_pop;
    logic             w_full;
    logic             w_push_acc;
    logic [1:0]       w_rd_idx;
    logic [2:0]       w_level_next;

    // r_trig_hold masks a trigger level already high out of reset, so only a
    // fresh low-to-high transition after reset counts as a push.
    assign w_edge     = bus.trig_write & ~r_trig_d & ~r_trig_hold & ~rst;
    assign w_pop      = (r_state == S_LOAD);
    assign w_full     = (r_level == 3'd4);
    assign w_push_acc = w_edge & (~w_full | w_pop);
    // level 4 wraps to index 3 in two bits, which is the intended oldest slot
    assign w_rd_idx   = r_level[1:0] - 2'd1;

    // trigger edge detector
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trig_d    <= 1'b0;
            r_trig_hold <= bus.trig_write;
        end else begin
            r_trig_d    <= bus.trig_write;
            r_trig_hold <= 1'b0;
        end
    end

    // shift storage; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[0] <= bus.din;
            for (int i = 1; i < 4; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    // next stored count, saturating at 0 and 4
    always_comb begin
        w_level_next = r_level;
        if (w_push_acc && !w_pop) begin
            if (r_level != 3'd4) w_level_next = r_level + 3'd1;
        end else if (w_pop && !w_push_acc) begin
            if (r_level != 3'd0) w_level_next = r_level - 3'd1;
        end
    end

    // stored entry counter
    always_ff @(posedge clk) begin
        if (rst) r_level <= 3'd0;
        else     r_level <= w_level_next;
    end

    // output stage sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_level != 3'd0) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_dout       <= r_mem[w_rd_idx];
                    r_dout_valid <= 1'b1;
                    r_state      <= S_VALID;
                end
                S_VALID: begin
                    // dout_valid drops during the reload so the same word is never accepted twice
                    if (bus.dout_ready) begin
                        r_dout_valid <= 1'b0;
                        r_state      <= (w_level_next != 3'd0) ? S_LOAD : S_IDLE;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_dout_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_READER_OVF_EN
    logic r_ovf;
    logic w_drop;
    assign w_drop = w_edge & w_full & ~w_pop;

    // sticky record of any dropped push
    always_ff @(posedge clk) begin
        if (rst)         r_ovf <= 1'b0;
        else if (w_drop) r_ovf <= 1'b1;
    end
    assign bus.ovf = r_ovf;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.level      = r_level;
    assign bus.empty      = (r_level == 3'd0);
    assign bus.full       = w_full;
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed and random stimulus against a queue-based reference.
module tb_fifo_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_reader_if #(.WIDTH(8)) bus ();

    fifo_reader #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference: stored entries oldest-first, plus the presented word
    logic [7:0] mq [$];
    logic [7:0] m_dout;
    bit         m_valid;
    bit         m_loading;
    bit         m_prev;
    bit         m_ovf;
    logic [7:0] got [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit edge_seen;
        bit pop;
        bit nxt_loading;
        int cnt;
        if (rst) begin
            mq.delete();
            m_dout = 8'h00; m_valid = 0; m_loading = 0; m_ovf = 0;
            m_prev = bus.trig_write;
            return;
        end
        edge_seen = bus.trig_write && !m_prev;
        m_prev = bus.trig_write;
        cnt = mq.size();
        pop = m_loading;
        nxt_loading = 0;
        if (pop) begin
            m_dout = mq.pop_front();
            m_valid = 1;
        end
        if (edge_seen) begin
            if (cnt < 4 || pop) mq.push_back(bus.din);
            else m_ovf = 1;
        end
        if (!pop) begin
            if (!m_valid) nxt_loading = (cnt != 0);
            else if (bus.dout_ready) begin
                m_valid = 0;
                nxt_loading = (mq.size() != 0);
            end
        end
        m_loading = nxt_loading;
    endtask

    task automatic compare_all();
        logic exp_ovf;
`ifdef FIFO_READER_OVF_EN
        exp_ovf = m_ovf;
`else
        exp_ovf = 1'b0;
`endif
        chk("dout_valid", bus.dout_valid, m_valid);
        chk("dout", bus.dout, m_dout);
        chk("level", bus.level, mq.size());
        chk("empty", bus.empty, mq.size() == 0);
        chk("full", bus.full, mq.size() == 4);
        chk("ovf", bus.ovf, exp_ovf);
    endtask

    task automatic tick();
        if (bus.dout_valid === 1'b1 && bus.dout_ready && !rst) got.push_back(bus.dout);
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic push(input logic [7:0] v);
        bus.trig_write = 1'b1; bus.din = v; tick();
        bus.trig_write = 1'b0; tick();
    endtask

    initial begin
        bus.trig_write = 1'b0;
        bus.din        = 8'h00;
        bus.dout_ready = 1'b0;

        // reset
        rst = 1'b1;
        ticks(2);
        chk("rst_level", bus.level, 3'd0);
        chk("rst_empty", bus.empty, 1'b1);
        chk("rst_full", bus.full, 1'b0);
        chk("rst_valid", bus.dout_valid, 1'b0);
        chk("rst_dout", bus.dout, 8'h00);
        chk("rst_ovf", bus.ovf, 1'b0);
        rst = 1'b0;
        tick();

        // latency and ordering
        got.delete();
        bus.dout_ready = 1'b1;
        bus.trig_write = 1'b1; bus.din = 8'hA1; tick();
        bus.trig_write = 1'b0; tick();
        chk("lat_c2_valid", bus.dout_valid, 1'b0);
        tick();
        chk("lat_c3_valid", bus.dout_valid, 1'b1);
        chk("lat_c3_dout", bus.dout, 8'hA1);
        push(8'hB2);
        push(8'hC3);
        ticks(12);
        chk("order_cnt", got.size(), 3);
        if (got.size() == 3) begin
            chk("order_0", got[0], 8'hA1);
            chk("order_1", got[1], 8'hB2);
            chk("order_2", got[2], 8'hC3);
        end

        // full and overflow
        got.delete();
        bus.dout_ready = 1'b0;
        for (int v = 1; v <= 6; v++) push(8'(v));
        ticks(3);
        chk("full_dout", bus.dout, 8'h01);
        chk("full_valid", bus.dout_valid, 1'b1);
        chk("full_level", bus.level, 3'd4);
        chk("full_flag", bus.full, 1'b1);
`ifdef FIFO_READER_OVF_EN
        chk("ovf_set", bus.ovf, 1'b1);
`else
        chk("ovf_tied", bus.ovf, 1'b0);
`endif
        bus.dout_ready = 1'b1;
        ticks(20);
        chk("drain_cnt", got.size(), 5);
        for (int i = 0; i < got.size() && i < 5; i++) chk("drain_val", got[i], 8'(i + 1));

        // simultaneous push and pop in the load cycle
        got.delete();
        bus.dout_ready = 1'b0;
        for (int v = 0; v < 5; v++) push(8'h11 + 8'(v));
        ticks(3);
        chk("sim_pre_level", bus.level, 3'd4);
        bus.dout_ready = 1'b1; tick();
        bus.dout_ready = 1'b0; bus.trig_write = 1'b1; bus.din = 8'h77; tick();
        chk("sim_level", bus.level, 3'd4);
        chk("sim_dout", bus.dout, 8'h12);
        bus.trig_write = 1'b0;
        tick();
        bus.dout_ready = 1'b1;
        ticks(20);
        chk("sim_cnt", got.size(), 6);
        if (got.size() == 6) chk("sim_last", got[5], 8'h77);

        // held trigger level gives a single push
        got.delete();
        bus.dout_ready = 1'b0;
        bus.trig_write = 1'b1; bus.din = 8'h5A;
        ticks(10);
        bus.trig_write = 1'b0;
        ticks(3);
        chk("hold_valid", bus.dout_valid, 1'b1);
        chk("hold_dout", bus.dout, 8'h5A);
        chk("hold_level", bus.level, 3'd0);
        bus.dout_ready = 1'b1;
        ticks(6);
        chk("hold_cnt", got.size(), 1);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            bus.trig_write = ($urandom_range(0, 2) != 0) ? ~bus.trig_write : bus.trig_write;
            bus.din        = 8'($urandom);
            bus.dout_ready = ($urandom_range(0, 3) == 0);
            rst            = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        bus.trig_write = 1'b0;
        bus.dout_ready = 1'b1;
        ticks(20);

        // reset in the middle of a transfer with the trigger high
        bus.dout_ready = 1'b0;
        for (int v = 0; v < 4; v++) push(8'hC0 + 8'(v));
        ticks(3);
        chk("mid_pre_level", bus.level, 3'd3);
        chk("mid_pre_valid", bus.dout_valid, 1'b1);
        rst = 1'b1; bus.trig_write = 1'b1;
        ticks(2);
        rst = 1'b0;
        ticks(5);
        chk("mid_level", bus.level, 3'd0);
        chk("mid_valid", bus.dout_valid, 1'b0);
        chk("mid_dout", bus.dout, 8'h00);
        chk("mid_ovf", bus.ovf, 1'b0);
        bus.trig_write = 1'b0; tick();
        bus.trig_write = 1'b1; bus.din = 8'h3C; tick();
        bus.trig_write = 1'b0;
        ticks(2);
        chk("mid_repush_valid", bus.dout_valid, 1'b1);
        chk("mid_repush_dout", bus.dout, 8'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
